// File: rtl/ltsm_sb_msg_bridge_pkg.sv
// Shared LTSM sideband definitions: message codes, substate ids and field widths.
// Constants and types only; no logic, so no latency or flow control applies.
package ltsm_sb_msg_bridge_pkg;

  localparam int MSG_W = 4;
  localparam int SUB_W = 4;

  typedef enum logic [MSG_W-1:0] {
    MSG_NONE       = 4'h0,
    MSG_START_REQ  = 4'h1,
    MSG_START_RESP = 4'h2,
    MSG_DONE_REQ   = 4'h3,
    MSG_DONE_RESP  = 4'h4,
    MSG_ERR_REQ    = 4'h5,
    MSG_ERR_RESP   = 4'h6
  } ltsm_msg_e;

  typedef enum logic [SUB_W-1:0] {
    SS_VALVREF          = 4'h0,
    SS_DATAVREF         = 4'h1,
    SS_SPEEDIDLE        = 4'h2,
    SS_TXSELFCAL        = 4'h3,
    SS_RXCLKCAL         = 4'h4,
    SS_VALTRAINCENTER   = 4'h5,
    SS_VALTRAINVREF     = 4'h6,
    SS_DATATRAINCENTER1 = 4'h7,
    SS_DATATRAINVREF    = 4'h8,
    SS_RXDESKEW         = 4'h9,
    SS_DATATRAINCENTER2 = 4'hA,
    SS_LINKSPEED        = 4'hB,
    SS_REPAIR           = 4'hC
  } ltsm_substate_e;

endpackage

// File: rtl/ltsm_sb_msg_bridge_fifo.sv
// DEPTH x W synchronous FIFO with count, full/empty and a synchronous flush.
// Write visible at the head next cycle; a write when full is accepted only alongside a read.
module sb_msg_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_wr,
  input  logic [W-1:0]             i_wdat,
  input  logic                     i_rd,
  output logic [W-1:0]             o_rdat,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_rd;
  logic          w_wr;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;
  assign o_rdat  = r_mem[r_rptr];

  assign w_rd = i_rd & ~o_empty;
  assign w_wr = i_wr & (~o_full | w_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= i_wdat;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ltsm_sb_msg_bridge.sv
// Queues wrapper message codes toward the sideband packetizer and filters received codes by substate.
// TX head appears 1 cycle after the write and holds until ready or timeout; RX valid lags by 1 cycle.
module ltsm_sb_msg_bridge #(
  parameter int DEPTH       = 2,
  parameter int TIMEOUT_CYC = 1024,
  parameter int MSG_W       = ltsm_sb_msg_bridge_pkg::MSG_W
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     i_en,
  input  logic [ltsm_sb_msg_bridge_pkg::SUB_W-1:0] i_substate,
  input  logic [MSG_W-1:0]                         i_ltsm_msg,
  input  logic                                     i_ltsm_valid,
  output logic                                     o_busy,
  output logic                                     o_falling_edge_busy,
  output logic [MSG_W-1:0]                         o_decoded_sideband_message,
  output logic                                     o_sideband_valid,
  output logic [MSG_W-1:0]                         o_tx_msg,
  output logic [ltsm_sb_msg_bridge_pkg::SUB_W-1:0] o_tx_substate,
  output logic                                     o_tx_valid,
  input  logic                                     i_tx_ready,
  input  logic [MSG_W-1:0]                         i_rx_msg,
  input  logic [ltsm_sb_msg_bridge_pkg::SUB_W-1:0] i_rx_substate,
  input  logic                                     i_rx_valid,
  output logic                                     o_tx_timeout,
  output logic                                     o_overflow
);

  import ltsm_sb_msg_bridge_pkg::*;

  localparam int ENT_W = SUB_W + MSG_W;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int TW    = $clog2(TIMEOUT_CYC);

  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic [ENT_W-1:0] w_head;
  logic             w_wr_req;
  logic             w_wr;
  logic             w_pop;
  logic             w_timeout;
  logic             w_busy;
  logic             w_rx_acc;

  logic [TW-1:0]    r_to_cnt;
  logic             r_busy_d;
  logic             r_overflow;
  logic             r_rx_vld;
  logic [MSG_W-1:0] r_rx_msg;

  assign w_wr_req  = i_en & i_ltsm_valid & (i_ltsm_msg != '0);
  assign w_timeout = i_en & ~w_empty & ~i_tx_ready & (r_to_cnt == TW'(TIMEOUT_CYC - 1));
  assign w_pop     = i_en & ~w_empty & (i_tx_ready | w_timeout);
  assign w_wr      = w_wr_req & (~w_full | w_pop);
  assign w_busy    = (w_count != '0);
  assign w_rx_acc  = i_en & i_rx_valid & (i_rx_substate == i_substate) & (i_rx_msg != '0);

  sb_msg_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (~i_en),
    .i_wr    (w_wr),
    .i_wdat  ({i_substate, i_ltsm_msg}),
    .i_rd    (w_pop),
    .o_rdat  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt   <= '0;
      r_busy_d   <= 1'b0;
      r_overflow <= 1'b0;
      r_rx_vld   <= 1'b0;
      r_rx_msg   <= '0;
    end else begin
      r_to_cnt   <= (~i_en | w_empty | w_pop) ? '0 : r_to_cnt + 1'b1;
      // Masking with i_en keeps a flush from looking like a normal drain.
      r_busy_d   <= w_busy & i_en;
      r_overflow <= i_en & (r_overflow | (w_wr_req & w_full & ~w_pop));
      r_rx_vld   <= w_rx_acc;
      if (w_rx_acc) r_rx_msg <= i_rx_msg;
    end
  end

  assign o_busy                     = w_busy;
  assign o_falling_edge_busy        = r_busy_d & ~w_busy;
  assign o_tx_valid                 = ~w_empty;
  assign o_tx_msg                   = w_head[MSG_W-1:0];
  assign o_tx_substate              = w_head[ENT_W-1:MSG_W];
  assign o_tx_timeout               = w_timeout;
  assign o_overflow                 = r_overflow;
  assign o_decoded_sideband_message = r_rx_msg;
  assign o_sideband_valid           = r_rx_vld;

endmodule

// File: tb/tb_ltsm_sb_msg_bridge.sv
// Directed bench for ltsm_sb_msg_bridge: TX/RX scoreboards checked by a monitor, plus inline
// cycle checks of busy, falling edge, overflow and timeout behaviour.
module tb_ltsm_sb_msg_bridge;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_en;
  logic [3:0] i_substate;
  logic [3:0] i_ltsm_msg;
  logic       i_ltsm_valid;
  logic       o_busy;
  logic       o_falling_edge_busy;
  logic [3:0] o_decoded_sideband_message;
  logic       o_sideband_valid;
  logic [3:0] o_tx_msg;
  logic [3:0] o_tx_substate;
  logic       o_tx_valid;
  logic       i_tx_ready;
  logic [3:0] i_rx_msg;
  logic [3:0] i_rx_substate;
  logic       i_rx_valid;
  logic       o_tx_timeout;
  logic       o_overflow;

  typedef struct {
    logic       to;
    logic [3:0] sub;
    logic [3:0] msg;
  } exp_t;

  exp_t       tx_q[$];
  logic [3:0] rx_q[$];
  int         n_checks = 0;
  int         n_err    = 0;

  ltsm_sb_msg_bridge #(
    .DEPTH       (2),
    .TIMEOUT_CYC (8),
    .MSG_W       (4)
  ) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .i_en                       (i_en),
    .i_substate                 (i_substate),
    .i_ltsm_msg                 (i_ltsm_msg),
    .i_ltsm_valid               (i_ltsm_valid),
    .o_busy                     (o_busy),
    .o_falling_edge_busy        (o_falling_edge_busy),
    .o_decoded_sideband_message (o_decoded_sideband_message),
    .o_sideband_valid           (o_sideband_valid),
    .o_tx_msg                   (o_tx_msg),
    .o_tx_substate              (o_tx_substate),
    .o_tx_valid                 (o_tx_valid),
    .i_tx_ready                 (i_tx_ready),
    .i_rx_msg                   (i_rx_msg),
    .i_rx_substate              (i_rx_substate),
    .i_rx_valid                 (i_rx_valid),
    .o_tx_timeout               (o_tx_timeout),
    .o_overflow                 (o_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic push_tx(input logic to, input logic [3:0] sub, input logic [3:0] msg);
    exp_t e;
    e.to  = to;
    e.sub = sub;
    e.msg = msg;
    tx_q.push_back(e);
  endtask

  // Monitor: every handshake or timeout discard must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (i_en && o_tx_valid && (i_tx_ready || o_tx_timeout)) begin
        if (tx_q.size() == 0) begin
          chk("tx_unexpected_pop", 1, 0);
        end else begin
          exp_t e;
          e = tx_q.pop_front();
          chk("tx_msg", o_tx_msg, e.msg);
          chk("tx_substate", o_tx_substate, e.sub);
          chk("tx_timeout_kind", o_tx_timeout, e.to);
        end
      end else if (o_tx_timeout) begin
        chk("tx_timeout_without_valid", 1, 0);
      end
      if (o_sideband_valid) begin
        if (rx_q.size() == 0) begin
          chk("rx_unexpected_pulse", 1, 0);
        end else begin
          logic [3:0] m;
          m = rx_q.pop_front();
          chk("rx_decoded", o_decoded_sideband_message, m);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nf;
    int nto;
    int to_cyc;
    int fe_cyc;

    rst_n = 1'b0; i_en = 1'b1; i_substate = 4'd0;
    i_ltsm_msg = 4'd0; i_ltsm_valid = 1'b0; i_tx_ready = 1'b0;
    i_rx_msg = 4'd0; i_rx_substate = 4'd0; i_rx_valid = 1'b0;
    mid();
    chk("rst_busy", o_busy, 0);
    chk("rst_tx_valid", o_tx_valid, 0);
    chk("rst_overflow", o_overflow, 0);
    chk("rst_decoded", o_decoded_sideband_message, 0);
    chk("rst_sb_valid", o_sideband_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Zero code is ignored
    i_ltsm_valid = 1'b1; i_ltsm_msg = 4'd0; i_substate = 4'd3;
    tick();
    i_ltsm_valid = 1'b0;
    mid();
    chk("zero_code_busy", o_busy, 0);

    // Single message
    tick();
    i_ltsm_valid = 1'b1; i_ltsm_msg = 4'd1; i_substate = 4'd3;
    push_tx(0, 4'd3, 4'd1);
    mid();
    chk("single_c0_busy", o_busy, 0);
    tick();
    i_ltsm_valid = 1'b0; i_ltsm_msg = 4'd0;
    mid();
    chk("single_c1_valid", o_tx_valid, 1);
    chk("single_c1_msg", o_tx_msg, 1);
    chk("single_c1_sub", o_tx_substate, 3);
    chk("single_c1_busy", o_busy, 1);
    tick();
    i_tx_ready = 1'b1;
    mid();
    chk("single_c2_busy", o_busy, 1);
    chk("single_c2_fe", o_falling_edge_busy, 0);
    tick();
    i_tx_ready = 1'b0;
    mid();
    chk("single_c3_fe", o_falling_edge_busy, 1);
    chk("single_c3_busy", o_busy, 0);
    tick();
    mid();
    chk("single_c4_fe", o_falling_edge_busy, 0);

    // Back-pressure and overflow
    tick();
    i_ltsm_valid = 1'b1; i_ltsm_msg = 4'd1; push_tx(0, 4'd3, 4'd1);
    tick();
    i_ltsm_msg = 4'd2; push_tx(0, 4'd3, 4'd2);
    tick();
    i_ltsm_msg = 4'd3;
    mid();
    chk("bp_overflow_before", o_overflow, 0);
    chk("bp_head_stable", o_tx_msg, 1);
    tick();
    i_ltsm_valid = 1'b0; i_ltsm_msg = 4'd0; i_tx_ready = 1'b1;
    mid();
    chk("bp_overflow_set", o_overflow, 1);
    tick();
    mid();
    chk("bp_second_head", o_tx_msg, 2);
    nf = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      i_tx_ready = 1'b0;
      mid();
      nf += int'(o_falling_edge_busy);
    end
    chk("bp_fe_count", nf, 1);
    chk("bp_overflow_sticky", o_overflow, 1);

    // Timeout with TIMEOUT_CYC=8: write at cycle 0, discard pulse at cycle 8
    tick();
    i_ltsm_valid = 1'b1; i_ltsm_msg = 4'd4; push_tx(1, 4'd3, 4'd4);
    nto = 0; to_cyc = -1; fe_cyc = -1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      i_ltsm_valid = 1'b0; i_ltsm_msg = 4'd0;
      mid();
      if (o_tx_timeout) begin nto++; to_cyc = c; end
      if (o_falling_edge_busy) fe_cyc = c;
    end
    chk("to_pulse_count", nto, 1);
    chk("to_pulse_cycle", to_cyc, 8);
    chk("to_fe_cycle", fe_cyc, 9);
    chk("to_queue_empty", o_tx_valid, 0);

    // RX filter
    tick();
    i_substate = 4'd5;
    i_rx_valid = 1'b1; i_rx_substate = 4'd5; i_rx_msg = 4'd2; rx_q.push_back(4'd2);
    tick();
    i_rx_substate = 4'd4; i_rx_msg = 4'd3;
    tick();
    i_rx_substate = 4'd5; i_rx_msg = 4'd0;
    mid();
    chk("rx_mismatch_no_pulse", o_sideband_valid, 0);
    chk("rx_mismatch_hold", o_decoded_sideband_message, 2);
    tick();
    i_rx_valid = 1'b0;
    mid();
    chk("rx_zero_no_pulse", o_sideband_valid, 0);
    tick();
    i_en = 1'b0; i_rx_valid = 1'b1; i_rx_msg = 4'd7;
    tick();
    i_en = 1'b1; i_rx_valid = 1'b0; i_rx_msg = 4'd0;
    mid();
    chk("rx_disabled_no_pulse", o_sideband_valid, 0);
    chk("rx_disabled_hold", o_decoded_sideband_message, 2);

    // Flush while full
    tick();
    i_ltsm_valid = 1'b1; i_ltsm_msg = 4'd1; push_tx(0, 4'd5, 4'd1);
    tick();
    i_ltsm_msg = 4'd2; push_tx(0, 4'd5, 4'd2);
    tick();
    i_ltsm_msg = 4'd3;
    tick();
    i_ltsm_valid = 1'b0; i_ltsm_msg = 4'd0; i_en = 1'b0;
    tx_q.delete();
    mid();
    chk("flush_overflow_pre", o_overflow, 1);
    chk("flush_busy_pre", o_busy, 1);
    tick();
    i_en = 1'b1;
    mid();
    chk("flush_busy", o_busy, 0);
    chk("flush_fe", o_falling_edge_busy, 0);
    chk("flush_overflow", o_overflow, 0);
    chk("flush_tx_valid", o_tx_valid, 0);
    tick();
    mid();
    chk("flush_fe_later", o_falling_edge_busy, 0);

    // Write while full with same-cycle pop, plus a same-cycle RX accept
    tick();
    i_ltsm_valid = 1'b1; i_ltsm_msg = 4'd6; push_tx(0, 4'd5, 4'd6);
    tick();
    i_ltsm_msg = 4'd7; push_tx(0, 4'd5, 4'd7);
    tick();
    i_ltsm_msg = 4'd8; push_tx(0, 4'd5, 4'd8); i_tx_ready = 1'b1;
    i_rx_valid = 1'b1; i_rx_substate = 4'd5; i_rx_msg = 4'd9; rx_q.push_back(4'd9);
    tick();
    i_ltsm_valid = 1'b0; i_ltsm_msg = 4'd0; i_tx_ready = 1'b0;
    i_rx_valid = 1'b0; i_rx_msg = 4'd0;
    mid();
    chk("simul_no_overflow", o_overflow, 0);
    chk("simul_busy", o_busy, 1);
    chk("simul_head", o_tx_msg, 7);
    chk("simul_rx_decoded", o_decoded_sideband_message, 9);
    tick();
    i_tx_ready = 1'b1;
    tick();
    tick();
    i_tx_ready = 1'b0;
    mid();
    chk("simul_drained", o_busy, 0);
    chk("simul_fe", o_falling_edge_busy, 1);
    chk("simul_overflow_end", o_overflow, 0);

    // Asynchronous reset mid-transfer
    tick();
    i_ltsm_valid = 1'b1; i_ltsm_msg = 4'd1; push_tx(0, 4'd5, 4'd1);
    tick();
    i_ltsm_msg = 4'd2; push_tx(0, 4'd5, 4'd2);
    tick();
    i_ltsm_msg = 4'd3;
    tick();
    i_ltsm_valid = 1'b0; i_ltsm_msg = 4'd0;
    mid();
    chk("arst_pre_overflow", o_overflow, 1);
    chk("arst_pre_valid", o_tx_valid, 1);
    #1;
    rst_n = 1'b0;
    tx_q.delete();
    #1;
    chk("arst_busy", o_busy, 0);
    chk("arst_fe", o_falling_edge_busy, 0);
    chk("arst_tx_valid", o_tx_valid, 0);
    chk("arst_tx_msg", o_tx_msg, 0);
    chk("arst_tx_sub", o_tx_substate, 0);
    chk("arst_timeout", o_tx_timeout, 0);
    chk("arst_overflow", o_overflow, 0);
    chk("arst_decoded", o_decoded_sideband_message, 0);
    chk("arst_sb_valid", o_sideband_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    chk("tx_scoreboard_empty", tx_q.size(), 0);
    chk("rx_scoreboard_empty", rx_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
